// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and reset constants for the register-file write arbiter.
package reg_file_ctrl_pkg;

  // CLEAR zeroes every register; RUN arbitrates the writeback sources.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_ctrl_state_e;

  localparam rf_ctrl_state_e RST_STATE = CLEAR;
  localparam logic           RST_WEN   = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid source at or above ptr_i,
// wrapping to source 0. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int NUM_REQ_P = 3,
  localparam int IW        = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1
) (
  input  logic [NUM_REQ_P-1:0] valid_i,
  input  logic [IW-1:0]        ptr_i,
  input  logic                 en_i,
  output logic [NUM_REQ_P-1:0] gnt_o,
  output logic [IW-1:0]        win_o
);

  logic [NUM_REQ_P-1:0] hi;
  logic                 found;

  // Search sources at/above the pointer first, then fall back to the low end.
  always_comb begin
    hi    = '0;
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ_P; j++)
      hi[j] = valid_i[j] && (IW'(j) >= ptr_i);
    for (int j = 0; j < NUM_REQ_P; j++)
      if (!found && hi[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        win_o    = IW'(j);
      end
    for (int j = 0; j < NUM_REQ_P; j++)
      if (!found && valid_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        win_o    = IW'(j);
      end
    if (!en_i) begin
      gnt_o = '0;
      win_o = '0;
    end
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin owner of the register file write port, with a zero-fill
// sequence after reset or on clear_i. All rf_* outputs are registered.
module reg_file_wr_arbiter
  import reg_file_ctrl_pkg::*;
#(
  parameter int NUM_REQ_P    = 3,
  parameter int addr_width_p = 6,
  parameter int data_width_p = 32,
  parameter int ZERO_REG_P   = 1
) (
  input  logic                              clk,
  input  logic                              rst_n_i,
  input  logic                              clear_i,
  input  logic [NUM_REQ_P-1:0]              req_valid_i,
  input  logic [NUM_REQ_P*addr_width_p-1:0] req_addr_i,
  input  logic [NUM_REQ_P*data_width_p-1:0] req_data_i,
  output logic [NUM_REQ_P-1:0]              req_ready_o,
  output logic                              rf_wen_o,
  output logic [addr_width_p-1:0]           rf_w_addr_o,
  output logic [data_width_p-1:0]           rf_w_data_o,
  output logic                              init_done_o
);

  localparam int IW = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1;

  rf_ctrl_state_e           state_q, state_d;
  logic [addr_width_p-1:0]  cnt_q;
  logic [IW-1:0]            ptr_q, win;
  logic [NUM_REQ_P-1:0]     gnt;
  logic                     arb_en, any_gnt, drop;
  logic [addr_width_p-1:0]  sel_addr;
  logic [data_width_p-1:0]  sel_data;

  // clear_i wins over any request in the same cycle.
  assign arb_en = (state_q == RUN) && !clear_i;

  rr_arbiter #(.NUM_REQ_P(NUM_REQ_P)) u_arb (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .gnt_o   (gnt),
    .win_o   (win)
  );

  assign req_ready_o = gnt;
  assign any_gnt     = |gnt;
  assign init_done_o = (state_q == RUN);

  // Mux the winning source's request onto the write path.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ_P; k++)
      if (gnt[k]) begin
        sel_addr = req_addr_i[k*addr_width_p +: addr_width_p];
        sel_data = req_data_i[k*data_width_p +: data_width_p];
      end
    drop = (ZERO_REG_P != 0) && (sel_addr == '0);
  end

  // Next state: leave CLEAR once the top address is loaded; clear_i re-enters it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (cnt_q == '1) state_d = RUN;
      RUN:     if (clear_i)     state_d = CLEAR;
      default: state_d = RST_STATE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) state_q <= RST_STATE;
    else          state_q <= state_d;

  // Clear address counter; wraps to 0 naturally after the top address.
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i)               cnt_q <= '0;
    else if (state_q == CLEAR)  cnt_q <= cnt_q + 1'b1;
    else                        cnt_q <= '0;

  // Round-robin pointer moves past every winner, dropped zero-reg writes included.
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i)     ptr_q <= '0;
    else if (any_gnt) ptr_q <= (win == IW'(NUM_REQ_P-1)) ? '0 : win + 1'b1;

  // Write port register: clear writes, granted writes, or idle (addr/data hold).
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) begin
      rf_wen_o    <= RST_WEN;
      rf_w_addr_o <= '0;
      rf_w_data_o <= '0;
    end else if (state_q == CLEAR) begin
      rf_wen_o    <= 1'b1;
      rf_w_addr_o <= cnt_q;
      rf_w_data_o <= '0;
    end else if (any_gnt && !drop) begin
      rf_wen_o    <= 1'b1;
      rf_w_addr_o <= sel_addr;
      rf_w_data_o <= sel_data;
    end else begin
      rf_wen_o    <= 1'b0;
    end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Bench: behavioural model (clear queue + rotating priority) checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_reg_file_wr_arbiter;
  localparam int N = 3, AW = 6, DW = 32, DEPTH = 1 << AW;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            rf_wen, init_done;
  logic [AW-1:0]   rf_addr;
  logic [DW-1:0]   rf_data;

  reg_file_wr_arbiter #(.NUM_REQ_P(N), .addr_width_p(AW), .data_width_p(DW), .ZERO_REG_P(1)) dut (
    .clk(clk), .rst_n_i(rst_n), .clear_i(clear),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready), .rf_wen_o(rf_wen), .rf_w_addr_o(rf_addr),
    .rf_w_data_o(rf_data), .init_done_o(init_done));

  always #5 clk = ~clk;

  // register file sitting behind the write port
  logic [DW-1:0] rf_mem [DEPTH];
  always @(posedge clk) if (rf_wen) rf_mem[rf_addr] <= rf_data;

  int checks = 0, errors = 0;

  // source-side request state
  bit            sv [N];
  logic [AW-1:0] sa [N];
  logic [DW-1:0] sd [N];
  bit            sclr = 1'b0;

  // model state
  int            m_ptr;
  int            clr_q [$];
  bit            e_wen;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [N-1:0]  e_gnt, last_gnt, dut_gnt;
  int            e_win;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    clr_q.delete();
    for (int i = 0; i < DEPTH; i++) clr_q.push_back(i);
    e_wen = 1'b0; e_addr = '0; e_data = '0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    for (int k = 0; k < N; k++) begin
      req_valid[k]          = sv[k];
      req_addr[k*AW +: AW]  = sa[k];
      req_data[k*DW +: DW]  = sd[k];
    end
    clear = sclr;
    #1;
    e_gnt = '0; e_win = -1;
    if (rst_n && clr_q.size() == 0 && !sclr)
      for (int i = 0; i < N; i++) begin
        automatic int k = (m_ptr + i) % N;
        if (sv[k]) begin e_win = k; e_gnt[k] = 1'b1; break; end
      end
    dut_gnt = req_ready;
    chk("ready", req_ready, e_gnt);
    chk("wen", rf_wen, e_wen);
    chk("init_done", init_done, rst_n && clr_q.size() == 0);
    if (e_wen || !rst_n) begin
      chk("addr", rf_addr, e_addr);
      chk("data", rf_data, e_data);
    end
    if (!rst_n) model_reset();
    else if (clr_q.size() != 0) begin
      e_wen = 1'b1; e_addr = AW'(clr_q.pop_front()); e_data = '0;
    end else if (sclr) begin
      for (int i = 0; i < DEPTH; i++) clr_q.push_back(i);
      e_wen = 1'b0;
    end else if (e_win >= 0) begin
      m_ptr = (e_win + 1) % N;
      if (sa[e_win] == 0) e_wen = 1'b0;
      else begin e_wen = 1'b1; e_addr = sa[e_win]; e_data = sd[e_win]; end
    end else e_wen = 1'b0;
    last_gnt = e_gnt;
    @(negedge clk);
  endtask

  task automatic rand_drive();
    for (int k = 0; k < N; k++) begin
      if (last_gnt[k]) sv[k] = 1'b0;
      if (!sv[k]) begin
        if ($urandom_range(0, 2) != 0) begin
          sv[k] = 1'b1;
          sa[k] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          sd[k] = $urandom;
        end
      end else if ($urandom_range(0, 19) == 0) sv[k] = 1'b0;
    end
    sclr = ($urandom_range(0, 149) == 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < N; k++) sv[k] = 1'b0;
    sclr = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wins [6];
    int exp_w [6] = '{0, 1, 2, 0, 1, 2};
    int n;
    bit hit;
    for (int k = 0; k < N; k++) begin sv[k] = 0; sa[k] = '0; sd[k] = '0; end
    last_gnt = '0;
    model_reset();
    @(negedge clk);
    repeat (2) tick();
    chk("rst_wen_lit", rf_wen, 0);
    chk("rst_addr_lit", rf_addr, 0);
    chk("rst_done_lit", init_done, 0);

    // clear after reset release: addr 0..63 on consecutive cycles
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      chk("clr_wen_lit", rf_wen, 1);
      chk("clr_addr_lit", rf_addr, i);
      if (i == DEPTH - 1) chk("done_at_top_lit", init_done, 1);
      tick();
    end

    // all three valid: grants rotate 0,1,2,0,1,2
    for (int k = 0; k < N; k++) begin
      sv[k] = 1'b1; sa[k] = AW'($urandom_range(1, DEPTH - 1)); sd[k] = $urandom;
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      wins[c] = -1;
      for (int k = 0; k < N; k++) if (dut_gnt[k]) wins[c] = k;
      chk("rr_order_lit", wins[c], exp_w[c]);
      for (int k = 0; k < N; k++)
        if (last_gnt[k]) begin sa[k] = AW'($urandom_range(1, DEPTH - 1)); sd[k] = $urandom; end
    end
    idle(2);

    // lone src1 write to addr 5
    sv[1] = 1'b1; sa[1] = 6'd5; sd[1] = 32'hDEAD_BEEF;
    tick();
    chk("src1_ready_lit", dut_gnt, 3'b010);
    sv[1] = 1'b0;
    chk("src1_wen_lit", rf_wen, 1);
    chk("src1_addr_lit", rf_addr, 5);
    tick();
    chk("rf5_lit", rf_mem[5], 32'hDEAD_BEEF);

    // src0 write to addr 0 is handshaken but dropped
    sv[0] = 1'b1; sa[0] = '0; sd[0] = 32'h1234;
    tick();
    chk("zero_ready_lit", dut_gnt, 3'b001);
    sv[0] = 1'b0;
    chk("zero_wen_lit", rf_wen, 0);
    sv[1] = 1'b1; sa[1] = 6'd9;  sd[1] = 32'h0000_0909;
    sv[2] = 1'b1; sa[2] = 6'd10; sd[2] = 32'h0000_0A0A;
    tick();
    chk("after_zero_gnt_lit", dut_gnt, 3'b010);
    sv[1] = 1'b0;
    tick();
    sv[2] = 1'b0;
    idle(2);
    chk("rf0_lit", rf_mem[0], 0);

    // clear pulsed the cycle after a grant of addr 7
    sv[0] = 1'b1; sa[0] = 6'd7; sd[0] = 32'hA5A5_0007;
    tick();
    sv[0] = 1'b0; sclr = 1'b1;
    tick();
    sclr = 1'b0;
    chk("rf7_written_lit", rf_mem[7], 32'hA5A5_0007);
    n = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (rf_wen) n++;
      tick();
    end
    chk("clear_write_count_lit", n, DEPTH);
    chk("rf7_cleared_lit", rf_mem[7], 0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      rand_drive();
      tick();
    end

    // reset asserted mid-clear at addr 20
    idle(DEPTH + 4);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (rf_wen && rf_addr == 6'd20) hit = 1'b1;
      else tick();
    end
    chk("reach_addr20", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wen_lit", rf_wen, 0);
    chk("async_rst_addr_lit", rf_addr, 0);
    chk("async_rst_data_lit", rf_data, 0);
    chk("async_rst_done_lit", init_done, 0);
    chk("async_rst_ready_lit", req_ready, 0);
    model_reset();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_wen_lit", rf_wen, 1);
    chk("restart_addr_lit", rf_addr, 0);
    repeat (DEPTH + 2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
